ex_mopa_unit: RTL and testbench
===============================

Name: ex_mopa_unit

Overview:
- Multi-cycle matrix outer-product-accumulate (MOPA) engine in the EX stage.
- Sits directly downstream of the ID/EX pipeline register and consumes its MOPA-related outputs.
- Computes M[r][j] += a[r]*b[j] on a 4x4 tile of signed 8-bit lanes, one tile row per cycle.
- Streams each updated row to the matrix register file and stalls the front of the pipeline while busy.

Parameters:
- XLEN, 32, width of scalar operands and of one tile row.
- LANES, 4, lanes per row and number of tile rows; lane width LANE_W = XLEN/LANES = 8.
- IDX_W, 2, width of the matrix tile index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_mopa_start  in  1  ID/EX holds a MOPA instruction (ex_matrix_write_mopa).
- ex_flush  in  1  kills the EX instruction; blocks a start only.
- ex_matrix_index  in  IDX_W  destination tile.
- ex_regs_data1  in  XLEN  vector a; lane k = bits [8k+7:8k].
- ex_regs_data2  in  XLEN  vector b, same lane layout.
- ex_M_flat  in  LANES*XLEN  current tile; row r = bits [32r+31:32r].
- mopa_stall  out  1  freeze PC, IF/ID and ID/EX.
- mopa_busy  out  1  FSM in BUSY.
- mopa_wr_en  out  1  row write strobe to matrix file.
- mopa_wr_index  out  IDX_W  tile being written.
- mopa_wr_row  out  2  row being written.
- mopa_wr_data  out  XLEN  updated row.
- mopa_done  out  1  single-cycle pulse on last row write.

Behaviour:
- Reset: rst low asynchronously forces state IDLE, row_cnt 0, and all operand latches to 0. Every output reads 0 while rst is low, including mopa_stall, which is gated by rst.
- Start condition: start = ex_mopa_start && !ex_flush && state==IDLE.
- IDLE:
  - On a rising edge with start true, latch a, b, the tile, and the index.
  - Set row_cnt to 0 and go to BUSY.
- BUSY:
  - Combinational outputs derived from registers only: mopa_wr_en=1, mopa_wr_row=row_cnt, mopa_wr_index=latched index.
  - mopa_wr_data lane j = trunc8(sext(M[row_cnt][j]) + a[row_cnt]*b[j]).
  - The product is signed 8x8 to 16 bit; the sum is 17-bit signed; the result is truncated to the low 8 bits (wrap).
  - Each edge increments row_cnt.
  - At row_cnt==LANES-1: mopa_done=1, then return to IDLE on the next edge.
- Timing, with the start cycle called cycle 0:
  - Rows 0..3 are written in cycles 1..4.
  - mopa_done is high in cycle 4.
  - The unit is idle again in cycle 5.
- mopa_stall = start || (state==BUSY && row_cnt != LANES-1).
  - High in cycles 0..3, low in cycle 4.
  - The MOPA instruction therefore leaves ID/EX at the end of cycle 4.
- ex_mopa_start is ignored while BUSY, so a held start never retriggers. A new MOPA may start in cycle 5; back-to-back starts are legal.
- ex_flush while BUSY is ignored. The running MOPA is older than any flushing branch and must complete.
- ex_flush together with ex_mopa_start in IDLE: no start, no stall, no writes.
- Operands are latched at start, so changes on the inputs during BUSY have no effect.
- Reset mid-operation aborts immediately. Rows already written stay written; remaining rows are never written.

Optional Feature:
- Macro: MOPA_SAT_EN.
- Defined: each lane sum is clamped to [-128, 127] (0x80..0x7F) before output.
- Undefined: two's-complement wrap (truncate to 8 bits).
- Timing and all other behaviour are identical in both builds.

Test Plan:
- Basic: a=0x04030201, b=0x01010101, tile all 0, index 2, start in cycle 0.
  - Expected: stall high cycles 0-3.
  - Expected writes: idx 2, rows 0..3 = 0x01010101, 0x02020202, 0x03030303, 0x04040404 in cycles 1-4.
  - Expected: done in cycle 4 only.
- Overflow: a=0x7F7F7F7F, b=0x02020202, every tile row 0x01010101.
  - Every row = 0xFFFFFFFF without MOPA_SAT_EN.
  - Every row = 0x7F7F7F7F with MOPA_SAT_EN.
- Negative: a=0x80808080, b=0x01010101, every tile row 0x80808080.
  - Every row = 0x00000000 wrapped.
  - Every row = 0x80808080 with MOPA_SAT_EN.
- Flush and retrigger:
  - Start with ex_flush=1 in the same cycle: stall, wr_en and done stay 0 for 6 cycles.
  - Start held high for cycles 0-4: exactly 4 writes.
  - Start again in cycle 5: a second 4-row sequence in cycles 6-9.
- Reset mid-op: drive rst low asynchronously in cycle 2.
  - All outputs go to 0 immediately.
  - After release: IDLE, no further writes, and a new start works normally.

Source files
------------

// File: rtl/ex_mopa_unit.sv
// ex_mopa_unit: EX-stage 4x4 int8 outer-product-accumulate engine, one tile row per cycle.
// Build option: define MOPA_SAT_EN to clamp each lane sum to int8 instead of wrapping.
module ex_mopa_unit #(
    parameter int XLEN  = 32,
    parameter int LANES = 4,
    parameter int IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_mopa_start,
    input  logic                    ex_flush,
    input  logic [IDX_W-1:0]        ex_matrix_index,
    input  logic [XLEN-1:0]         ex_regs_data1,
    input  logic [XLEN-1:0]         ex_regs_data2,
    input  logic [LANES*XLEN-1:0]   ex_M_flat,
    output logic                    mopa_stall,
    output logic                    mopa_busy,
    output logic                    mopa_wr_en,
    output logic [IDX_W-1:0]        mopa_wr_index,
    output logic [1:0]              mopa_wr_row,
    output logic [XLEN-1:0]         mopa_wr_data,
    output logic                    mopa_done
);
    localparam int LANE_W = XLEN / LANES;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_nx;
    logic [1:0]              row_cnt;
    logic [XLEN-1:0]         a_q, b_q;
    logic [LANES*XLEN-1:0]   m_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    start, busy, last;
    logic [XLEN-1:0]         row_data;

    assign busy      = state == BUSY;
    assign last      = row_cnt == 2'(LANES - 1);
    assign start     = ex_mopa_start && !ex_flush && state == IDLE;
    assign mopa_busy = busy;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // operand latches captured at start; row counter advances every busy cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            idx_q   <= '0;
        end else if (start) begin
            row_cnt <= '0;
            a_q     <= ex_regs_data1;
            b_q     <= ex_regs_data2;
            m_q     <= ex_M_flat;
            idx_q   <= ex_matrix_index;
        end else if (busy) begin
            row_cnt <= row_cnt + 2'd1;
        end
    end

    // per-lane accumulate of the current row: M[row][j] + a[row]*b[j]
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [LANE_W-1:0] a_l, b_l, m_l;
        assign a_l = a_q[int'(row_cnt)*LANE_W +: LANE_W];
        assign b_l = b_q[j*LANE_W +: LANE_W];
        assign m_l = m_q[int'(row_cnt)*XLEN + j*LANE_W +: LANE_W];
`ifdef MOPA_SAT_EN
        localparam int SUM_W = 2*LANE_W + 1;
        localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'((2**(LANE_W-1)) - 1);
        localparam logic signed [SUM_W-1:0] S_MIN = SUM_W'(-(2**(LANE_W-1)));
        logic signed [SUM_W-1:0] sum;
        assign sum = SUM_W'(m_l) + SUM_W'(a_l) * SUM_W'(b_l);
        assign row_data[j*LANE_W +: LANE_W] = (sum > S_MAX) ? S_MAX[LANE_W-1:0] :
                                              (sum < S_MIN) ? S_MIN[LANE_W-1:0] : sum[LANE_W-1:0];
`else
        // low 8 bits of the 17-bit sum equal the 8-bit wrapped sum of the truncated terms
        assign row_data[j*LANE_W +: LANE_W] = m_l + a_l * b_l;
`endif
    end

    // next state and output decode; stall is forced low while reset is held
    always_comb begin
        state_nx      = state;
        mopa_wr_en    = 1'b0;
        mopa_wr_index = '0;
        mopa_wr_row   = '0;
        mopa_wr_data  = '0;
        mopa_done     = 1'b0;
        if (start) state_nx = BUSY;
        if (busy) begin
            state_nx      = last ? IDLE : BUSY;
            mopa_wr_en    = 1'b1;
            mopa_wr_index = idx_q;
            mopa_wr_row   = row_cnt;
            mopa_wr_data  = row_data;
            mopa_done     = last;
        end
        mopa_stall = rst && (start || (busy && !last));
    end
endmodule

// File: tb/tb_ex_mopa_unit.sv
// tb_ex_mopa_unit: scoreboard bench for ex_mopa_unit (follows MOPA_SAT_EN like the RTL).
module tb_ex_mopa_unit;
    logic         clk, rst;
    logic         ex_mopa_start, ex_flush;
    logic [1:0]   ex_matrix_index;
    logic [31:0]  ex_regs_data1, ex_regs_data2;
    logic [127:0] ex_M_flat;
    logic         mopa_stall, mopa_busy, mopa_wr_en, mopa_done;
    logic [1:0]   mopa_wr_index, mopa_wr_row;
    logic [31:0]  mopa_wr_data;

    typedef struct {
        logic [1:0]  idx;
        logic [1:0]  row;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_wr = 0;

    ex_mopa_unit dut (
        .clk(clk), .rst(rst),
        .ex_mopa_start(ex_mopa_start), .ex_flush(ex_flush),
        .ex_matrix_index(ex_matrix_index),
        .ex_regs_data1(ex_regs_data1), .ex_regs_data2(ex_regs_data2),
        .ex_M_flat(ex_M_flat),
        .mopa_stall(mopa_stall), .mopa_busy(mopa_busy), .mopa_wr_en(mopa_wr_en),
        .mopa_wr_index(mopa_wr_index), .mopa_wr_row(mopa_wr_row),
        .mopa_wr_data(mopa_wr_data), .mopa_done(mopa_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_row(input logic [31:0] a, input logic [31:0] b,
                                            input logic [127:0] m, input int r);
        logic [31:0] res;
        int s;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            s = int'($signed(m[32*r + 8*j +: 8])) + int'($signed(a[8*r +: 8])) * int'($signed(b[8*j +: 8]));
`ifdef MOPA_SAT_EN
            if (s > 127) s = 127;
            else if (s < -128) s = -128;
`endif
            res[8*j +: 8] = s[7:0];
        end
        return res;
    endfunction

    task automatic push_rows(input logic [31:0] a, input logic [31:0] b,
                             input logic [127:0] m, input logic [1:0] idx);
        for (int r = 0; r < 4; r++) q.push_back('{idx: idx, row: 2'(r), data: exp_row(a, b, m, r)});
    endtask

    // observe the current cycle's outputs, then advance to the next negedge
    task automatic tick(input logic exp_stall, input logic exp_done);
        wr_t e;
        #1;
        check("stall", mopa_stall, exp_stall);
        check("done", mopa_done, exp_done);
        if (mopa_wr_en) begin
            if (q.size() == 0) check("wr_unexpected", mopa_wr_en, 1'b0);
            else begin
                e = q.pop_front();
                n_wr++;
                check("wr_idx", mopa_wr_index, e.idx);
                check("wr_row", mopa_wr_row, e.row);
                check("wr_data", mopa_wr_data, e.data);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"}, mopa_stall, 0);
        check({tag, "_busy"}, mopa_busy, 0);
        check({tag, "_wr_en"}, mopa_wr_en, 0);
        check({tag, "_wr_idx"}, mopa_wr_index, 0);
        check({tag, "_wr_row"}, mopa_wr_row, 0);
        check({tag, "_wr_data"}, mopa_wr_data, 0);
        check({tag, "_done"}, mopa_done, 0);
    endtask

    // full MOPA; operands and flush are scrambled while busy to prove latching
    task automatic run_mopa(input logic [31:0] a, input logic [31:0] b,
                            input logic [127:0] m, input logic [1:0] idx);
        ex_mopa_start = 1'b1;
        ex_flush = 1'b0;
        ex_regs_data1 = a;
        ex_regs_data2 = b;
        ex_M_flat = m;
        ex_matrix_index = idx;
        push_rows(a, b, m, idx);
        tick(1'b1, 1'b0);
        ex_mopa_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            ex_regs_data1 = $urandom;
            ex_regs_data2 = $urandom;
            ex_M_flat = {$urandom, $urandom, $urandom, $urandom};
            ex_matrix_index = 2'($urandom);
            ex_flush = 1'($urandom_range(0, 1));
            tick(c < 4, c == 4);
        end
        ex_flush = 1'b0;
        check("sb_empty", q.size(), 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        ex_mopa_start = 1'b1;
        ex_flush = 1'b0;
        ex_matrix_index = '0;
        ex_regs_data1 = '0;
        ex_regs_data2 = '0;
        ex_M_flat = '0;
        #1 rst = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        check_zero("reset_hold");
        ex_mopa_start = 1'b0;
        rst = 1'b1;
        tick(1'b0, 1'b0);

        run_mopa(32'h04030201, 32'h01010101, '0, 2'd2);
        run_mopa(32'h7F7F7F7F, 32'h02020202, {4{32'h01010101}}, 2'd1);
        run_mopa(32'h80808080, 32'h01010101, {4{32'h80808080}}, 2'd3);
        run_mopa(32'h80808080, 32'h80808080, {4{32'h7F7F7F7F}}, 2'd0);

        // start killed by flush: nothing happens
        base = n_wr;
        ex_mopa_start = 1'b1;
        ex_flush = 1'b1;
        for (int c = 0; c < 6; c++) tick(1'b0, 1'b0);
        check("flush_busy", mopa_busy, 0);
        check("flush_writes", n_wr - base, 0);
        ex_mopa_start = 1'b0;
        ex_flush = 1'b0;

        // start held through the whole op, then a back-to-back second op in cycle 5
        base = n_wr;
        ex_mopa_start = 1'b1;
        ex_regs_data1 = 32'h11223344;
        ex_regs_data2 = 32'hF0E0D0C0;
        ex_M_flat = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        ex_matrix_index = 2'd1;
        push_rows(ex_regs_data1, ex_regs_data2, ex_M_flat, ex_matrix_index);
        tick(1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) tick(c < 4, c == 4);
        check("held_writes", n_wr - base, 4);
        ex_regs_data1 = 32'hFF01807F;
        ex_regs_data2 = 32'h7F80FF03;
        ex_M_flat = {32'h80FF7F00, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
        ex_matrix_index = 2'd3;
        push_rows(ex_regs_data1, ex_regs_data2, ex_M_flat, ex_matrix_index);
        tick(1'b1, 1'b0);
        ex_mopa_start = 1'b0;
        for (int c = 6; c <= 9; c++) tick(c < 9, c == 9);
        tick(1'b0, 1'b0);
        check("b2b_writes", n_wr - base, 8);
        check("sb_empty_b2b", q.size(), 0);

        // asynchronous reset in the middle of an op
        base = n_wr;
        ex_mopa_start = 1'b1;
        ex_regs_data1 = 32'h01020304;
        ex_regs_data2 = 32'h05060708;
        ex_M_flat = '0;
        ex_matrix_index = 2'd2;
        push_rows(ex_regs_data1, ex_regs_data2, ex_M_flat, ex_matrix_index);
        tick(1'b1, 1'b0);
        ex_mopa_start = 1'b0;
        tick(1'b1, 1'b0);
        check("pre_rst_writes", n_wr - base, 1);
        ex_mopa_start = 1'b1;
        rst = 1'b0;
        #1 check_zero("midop_rst");
        q.delete();
        @(negedge clk);
        check_zero("midop_rst_hold");
        ex_mopa_start = 1'b0;
        rst = 1'b1;
        base = n_wr;
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
        check("post_rst_writes", n_wr - base, 0);
        check("post_rst_busy", mopa_busy, 0);
        run_mopa(32'h04030201, 32'h01010101, '0, 2'd2);

        for (int i = 0; i < 5; i++)
            run_mopa($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom}, 2'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
